// File: rtl/button_bank.sv
// Multi-channel button debouncer: 2-flop synchronizer, per-channel stability
// counter, registered level/press/release outputs and optional latched press flags.
module button_bank #(
    parameter int CHANNELS      = 8,
    parameter int COUNTER_SIZE  = 8,
    parameter int COUNTER_VALUE = 255,
    parameter int STICKY        = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] button_in,
    input  logic [CHANNELS-1:0] clear_in,
    output logic [CHANNELS-1:0] state_out,
    output logic [CHANNELS-1:0] press_out,
    output logic [CHANNELS-1:0] release_out,
    output logic [CHANNELS-1:0] sticky_out,
    output logic                any_pressed
);

    localparam logic [COUNTER_SIZE-1:0] COUNT_MAX = COUNTER_SIZE'(COUNTER_VALUE);
    localparam logic [COUNTER_SIZE-1:0] COUNT_ONE = COUNTER_SIZE'(1);

    // Declaration initialisers make power-up contents match the reset values.
    logic [CHANNELS-1:0]     sync1     = '0;
    logic [CHANNELS-1:0]     sync2     = '0;
    logic [CHANNELS-1:0]     state_q   = '0;
    logic [CHANNELS-1:0]     press_q   = '0;
    logic [CHANNELS-1:0]     release_q = '0;
    logic [CHANNELS-1:0]     sticky_q  = '0;
    logic [COUNTER_SIZE-1:0] count [CHANNELS] = '{default: '0};

    logic [CHANNELS-1:0] mismatch;
    logic [CHANNELS-1:0] toggle;

    always_comb begin
        mismatch = '0;
        toggle   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            mismatch[i] = (sync2[i] != state_q[i]);
            toggle[i]   = mismatch[i] && (count[i] == COUNT_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= '0;
            sync2     <= '0;
            state_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            sticky_q  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                count[i] <= '0;
            end
        end else begin
            sync1     <= button_in;
            sync2     <= sync1;
            state_q   <= state_q ^ toggle;
            press_q   <= toggle & sync2;
            release_q <= toggle & ~sync2;
            // A press on the same cycle as a clear keeps the flag set.
            if (STICKY != 0) begin
                sticky_q <= (sticky_q & ~clear_in) | (toggle & sync2);
            end else begin
                sticky_q <= '0;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (!mismatch[i] || toggle[i]) begin
                    count[i] <= '0;
                end else begin
                    count[i] <= count[i] + COUNT_ONE;
                end
            end
        end
    end

    assign state_out   = state_q;
    assign press_out   = press_q;
    assign release_out = release_q;
    assign sticky_out  = sticky_q;
    assign any_pressed = |state_q;

endmodule

// File: doc/button_bank.md
BUTTON_BANK -- requirements
Module: button_bank

Interface
REQ-001 Parameter CHANNELS, default 8, number of independent button channels (>=1).
REQ-002 Parameter COUNTER_SIZE, default 8, debounce counter width per channel.
REQ-003 Parameter COUNTER_VALUE, default 255, stability threshold (1 <= COUNTER_VALUE <= 2^COUNTER_SIZE-1).
REQ-004 Parameter STICKY, default 1, 1 enables per-channel latched press flags, 0 disables them.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 button_in  input  CHANNELS  raw asynchronous button levels, 1 = pressed.
REQ-008 clear_in  input  CHANNELS  per-channel sticky-flag clear, level, sampled each cycle.
REQ-009 state_out  output  CHANNELS  debounced button level, registered.
REQ-010 press_out  output  CHANNELS  one-cycle pulse on debounced 0->1 transition, registered.
REQ-011 release_out  output  CHANNELS  one-cycle pulse on debounced 1->0 transition, registered.
REQ-012 sticky_out  output  CHANNELS  latched "pressed since last clear" flags, registered.
REQ-013 any_pressed  output  1  OR-reduction of state_out.

Function
REQ-014 Each button_in bit SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-015 Per channel, mismatch = (sync2 != state_out[i]).
REQ-016 Counter SHALL reset to 0 on any cycle with no mismatch.
REQ-017 Counter SHALL increment by 1 on a mismatch cycle while counter < COUNTER_VALUE.
REQ-018 On a mismatch cycle with counter == COUNTER_VALUE: state_out[i] toggles, counter resets to 0, and press_out[i] (new state 1) or release_out[i] (new state 0) is 1 for exactly the next cycle.
REQ-019 Counter SHALL never exceed COUNTER_VALUE and SHALL never wrap.
REQ-020 Latency: a clean button_in change reaches state_out after exactly COUNTER_VALUE+3 rising edges (2 sync + COUNTER_VALUE+1 stable-mismatch edges).
REQ-021 A glitch shorter than COUNTER_VALUE+1 synchronized cycles SHALL produce no state change and no pulse.
REQ-022 press_out and release_out SHALL be 0 on every cycle without a toggle; they are never both 1 on the same channel.
REQ-023 STICKY=1: sticky_out[i] sets on the cycle press_out[i] asserts and stays set until a cycle with clear_in[i]=1 and no concurrent press toggle.
REQ-024 Simultaneous press toggle and clear_in[i]=1 SHALL leave sticky_out[i]=1 (set wins).
REQ-025 STICKY=0: sticky_out SHALL be constant 0 and clear_in ignored.
REQ-026 Channels SHALL be fully independent; activity on one never alters another's counter, outputs or flags.
REQ-027 any_pressed SHALL equal |state_out in the same cycle (combinational from registers).

Reset
REQ-028 While reset=1: sync flops, counters, state_out, press_out, release_out, sticky_out all 0; any_pressed 0.
REQ-029 Reset mid-debounce SHALL discard partial counts; debounce restarts from 0 after reset deasserts.
REQ-030 A button held through reset SHALL generate a press_out pulse COUNTER_VALUE+3 edges after reset deasserts.
REQ-031 Initial (power-up) register values SHALL equal reset values.

Verification (CHANNELS=4, COUNTER_VALUE=3, COUNTER_SIZE=2, STICKY=1)
REQ-032 Hold button_in=4'b0001 from cycle 0 -> state_out[0]=1 and press_out=4'b0001 for one cycle at edge 6; sticky_out[0]=1 from then; any_pressed=1.
REQ-033 Pulse button_in[1] high for 3 cycles then low -> state_out, press_out, sticky_out stay 0 on channel 1.
REQ-034 After REQ-032, drop button_in[0] -> release_out[0] pulses once at edge 6 after the drop; sticky_out[0] still 1; assert clear_in[0] one cycle -> sticky_out[0]=0 next cycle.
REQ-035 Assert clear_in[2]=1 on the exact cycle channel 2's press toggles -> sticky_out[2]=1 afterwards.
REQ-036 Hold button_in[3]=1, assert reset at counter==2 for one cycle -> no pulse; press_out[3] pulses 6 edges after reset deasserts.
REQ-037 Drive all four channels with staggered independent patterns -> each channel's outputs match a per-channel reference model every cycle.
